// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-clock divider
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FP_AT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_AT  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_FP_AT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_AT  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    logic [3:0] div_q, div_d;
    logic       pix_tick_q, pix_tick_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    phase_e     h_state_q, h_state_d;
    phase_e     v_state_q, v_state_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Divider and raster counters; pix_tick is registered so it marks the last clk of each pixel.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        pix_tick_d = (div_d == DIV_LAST);
        x_d        = x_q;
        y_d        = y_q;
        if (pix_tick_q) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Horizontal/vertical phase FSMs, stepped by the next coordinate so phases never lag x/y.
    always_comb begin
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (pix_tick_q) begin
            case (h_state_q)
                PH_ACTIVE: if (x_d == H_FP_AT) h_state_d = PH_FP;
                PH_FP:     if (x_d == H_SY_AT) h_state_d = PH_SYNC;
                PH_SYNC:   if (x_d == H_BP_AT) h_state_d = PH_BP;
                PH_BP:     if (x_d == 10'd0)   h_state_d = PH_ACTIVE;
                default:   h_state_d = PH_BP;
            endcase
            if (x_q == H_LAST) begin
                case (v_state_q)
                    PH_ACTIVE: if (y_d == V_FP_AT) v_state_d = PH_FP;
                    PH_FP:     if (y_d == V_SY_AT) v_state_d = PH_SYNC;
                    PH_SYNC:   if (y_d == V_BP_AT) v_state_d = PH_BP;
                    PH_BP:     if (y_d == 10'd0)   v_state_d = PH_ACTIVE;
                    default:   v_state_d = PH_BP;
                endcase
            end
        end
    end

    // Output decode from the next state so the registered outputs line up with the new x/y.
    always_comb begin
        hsync_d       = (h_state_d != PH_SYNC);
        vsync_d       = (v_state_d != PH_SYNC);
        active_d      = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
        line_start_d  = (x_d == 10'd0);
        frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    end

    // State registers; reset parks the raster on the last pixel of the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= 4'd0;
            pix_tick_q    <= 1'b0;
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            h_state_q     <= PH_BP;
            v_state_q     <= PH_BP;
            active_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
